// File: rtl/data_memory_stage_if.sv
// rtl/data_memory_stage_if.sv - request/response bundle between the datapath and the data memory stage
// Signals:
//   memRead, memWrite  - load / store request for the current instruction (master -> slave)
//   address            - byte address, the ALU result (master -> slave)
//   writeData          - store data (master -> slave)
//   funct3             - access size/sign, present only with DMEM_SUBWORD_EN (master -> slave)
//   readData           - registered load data (slave -> master)
//   accessDone         - one-clock pulse on a requested access edge (slave -> master)
//   addrError          - sticky misaligned / out-of-range flag (slave -> master)
// Optional feature macro: DMEM_SUBWORD_EN
interface data_memory_stage_if;
    logic        memRead;
    logic        memWrite;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        accessDone;
    logic        addrError;
`ifdef DMEM_SUBWORD_EN
    logic [2:0]  funct3;

    modport master (
        output memRead, memWrite, address, writeData, funct3,
        input  readData, accessDone, addrError
    );
    modport slave (
        input  memRead, memWrite, address, writeData, funct3,
        output readData, accessDone, addrError
    );
`else
    modport master (
        output memRead, memWrite, address, writeData,
        input  readData, accessDone, addrError
    );
    modport slave (
        input  memRead, memWrite, address, writeData,
        output readData, accessDone, addrError
    );
`endif
endinterface

// File: rtl/data_memory_stage.sv
// rtl/data_memory_stage.sv - phased word-organised data memory downstream of the ALU
// One load or store per 10-phase instruction period; the access edge is the edge
// leaving phase ACCESS_PHASE, one phase after the ALU result is registered.
// Ports:
//   clock  - datapath clock
//   reset  - synchronous, active-high; clears phase and outputs, never the memory array
//   bus    - data_memory_stage_if.slave (requests in; readData/accessDone/addrError out)
// Optional feature macro: DMEM_SUBWORD_EN (adds bus.funct3 byte/halfword access)
module data_memory_stage #(
    parameter int DEPTH        = 256,
    parameter int ADDR_BITS    = 8,
    parameter int ACCESS_PHASE = 4
) (
    input  logic               clock,
    input  logic               reset,
    data_memory_stage_if.slave bus
);
    localparam logic [3:0] LAST_PHASE = 4'd9;
    localparam logic [3:0] ACC_PHASE  = 4'(ACCESS_PHASE);

    logic [3:0]           phase_q, phase_d;
    logic [31:0]          read_data_q, read_data_d;
    logic                 access_done_q, access_done_d;
    logic                 addr_error_q, addr_error_d;
    logic [31:0]          mem_q [DEPTH];

    logic                 access_edge;
    logic                 request;
    logic                 in_range;
    logic                 aligned;
    logic                 size_ok;
    logic                 valid;
    logic                 do_write;
    logic [ADDR_BITS-1:0] word_idx;
    logic [31:0]          old_word;
    logic [31:0]          load_value;
    logic [31:0]          store_word;

    assign access_edge = (phase_q == ACC_PHASE);
    assign request     = bus.memRead || bus.memWrite;
    assign word_idx    = bus.address[ADDR_BITS+1:2];
    assign in_range    = (bus.address[31:ADDR_BITS+2] == '0);
    // Pre-write contents: the read path sees this even when a store lands on the same edge.
    assign old_word    = mem_q[word_idx];

`ifdef DMEM_SUBWORD_EN
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic        load_ok;
    logic        store_ok;

    assign sel_byte = old_word[{bus.address[1:0], 3'b000} +: 8];
    assign sel_half = old_word[{bus.address[1], 4'b0000} +: 16];

    // Sub-word stores become a read-modify-write of the whole word so only the
    // selected byte lanes change.
    always_comb begin
        aligned    = 1'b0;
        load_ok    = 1'b0;
        store_ok   = 1'b0;
        load_value = old_word;
        store_word = old_word;
        case (bus.funct3)
            3'b000: begin
                aligned    = 1'b1;
                load_ok    = 1'b1;
                store_ok   = 1'b1;
                load_value = {{24{sel_byte[7]}}, sel_byte};
                store_word[{bus.address[1:0], 3'b000} +: 8] = bus.writeData[7:0];
            end
            3'b001: begin
                aligned    = ~bus.address[0];
                load_ok    = 1'b1;
                store_ok   = 1'b1;
                load_value = {{16{sel_half[15]}}, sel_half};
                store_word[{bus.address[1], 4'b0000} +: 16] = bus.writeData[15:0];
            end
            3'b010: begin
                aligned    = (bus.address[1:0] == 2'b00);
                load_ok    = 1'b1;
                store_ok   = 1'b1;
                store_word = bus.writeData;
            end
            3'b100: begin
                aligned    = 1'b1;
                load_ok    = 1'b1;
                load_value = {24'd0, sel_byte};
            end
            3'b101: begin
                aligned    = ~bus.address[0];
                load_ok    = 1'b1;
                load_value = {16'd0, sel_half};
            end
            default: aligned = 1'b0;
        endcase
    end

    // Unsigned encodings exist only for loads, so a store with them is invalid.
    assign size_ok = (!bus.memRead || load_ok) && (!bus.memWrite || store_ok);
`else
    assign aligned    = (bus.address[1:0] == 2'b00);
    assign size_ok    = 1'b1;
    assign load_value = old_word;
    assign store_word = bus.writeData;
`endif

    assign valid    = aligned && in_range && size_ok;
    assign do_write = access_edge && bus.memWrite && valid;

    always_comb begin
        phase_d       = (phase_q == LAST_PHASE) ? 4'd0 : phase_q + 4'd1;
        read_data_d   = read_data_q;
        access_done_d = 1'b0;
        addr_error_d  = addr_error_q;
        if (access_edge) begin
            access_done_d = request;
            if (bus.memRead) begin
                read_data_d = valid ? load_value : 32'd0;
            end
            if (request && !valid) begin
                addr_error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q       <= 4'd0;
            read_data_q   <= 32'd0;
            access_done_q <= 1'b0;
            addr_error_q  <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            read_data_q   <= read_data_d;
            access_done_q <= access_done_d;
            addr_error_q  <= addr_error_d;
        end
    end

    // Array kept out of the reset block: contents survive reset.
    always_ff @(posedge clock) begin
        if (!reset && do_write) begin
            mem_q[word_idx] <= store_word;
        end
    end

    assign bus.readData   = read_data_q;
    assign bus.accessDone = access_done_q;
    assign bus.addrError  = addr_error_q;
endmodule

// File: tb/tb_data_memory_stage.sv
// tb/tb_data_memory_stage.sv - table-driven scoreboard bench for data_memory_stage
module tb_data_memory_stage;
    logic clock;
    logic reset;

    data_memory_stage_if dmem_bus ();

    data_memory_stage #(
        .DEPTH       (256),
        .ADDR_BITS   (8),
        .ACCESS_PHASE(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (dmem_bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        done;
        logic        err;
        int          row;
    } exp_t;

    vec_t        tbl[$];
    exp_t        sb[$];
    int          n_vec;
    int          n_err;
    int          ph_m;
    logic [31:0] last_rd;
    logic        last_err;

    function automatic vec_t mk(logic rd, logic wr, logic [2:0] f3, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] exp_rd, logic exp_done,
                                logic exp_err);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_rd = exp_rd; v.exp_done = exp_done; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(logic rd, logic wr, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata);
        dmem_bus.memRead   = rd;
        dmem_bus.memWrite  = wr;
        dmem_bus.address   = addr;
        dmem_bus.writeData = wdata;
`ifdef DMEM_SUBWORD_EN
        dmem_bus.funct3    = f3;
`else
        if (f3 != 3'b010) $display("note: funct3 %0d ignored in word-only build", f3);
`endif
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        ph_m = (ph_m == 9) ? 0 : ph_m + 1;
    endtask

    // Random requests on non-access edges must leave every output untouched.
    task automatic run_vec(int row, vec_t v);
        exp_t e;
        logic [31:0] ja;
        while (ph_m != 4) begin
            ja = $urandom;
            if ($urandom_range(0, 1) == 1) ja = ja & 32'h0000_03FC;
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'b010, ja, $urandom);
            step();
            check($sformatf("row%0d idle accessDone", row), {31'd0, dmem_bus.accessDone}, 32'd0);
            check($sformatf("row%0d idle readData", row), dmem_bus.readData, last_rd);
            check($sformatf("row%0d idle addrError", row), {31'd0, dmem_bus.addrError}, {31'd0, last_err});
        end
        drive(v.rd, v.wr, v.f3, v.addr, v.wdata);
        e.rdata = v.exp_rd; e.done = v.exp_done; e.err = v.exp_err; e.row = row;
        sb.push_back(e);
        step();
        e = sb.pop_front();
        check($sformatf("row%0d readData", e.row), dmem_bus.readData, e.rdata);
        check($sformatf("row%0d accessDone", e.row), {31'd0, dmem_bus.accessDone}, {31'd0, e.done});
        check($sformatf("row%0d addrError", e.row), {31'd0, dmem_bus.addrError}, {31'd0, e.err});
        last_rd  = e.rdata;
        last_err = e.err;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        drive(1'b0, 1'b0, 3'b010, 32'd0, 32'd0);

        //       rd    wr    f3      addr          wdata          exp_rd         done  err
        tbl.push_back(mk(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 3'b010, 32'h0000_0020, 32'h1111_1111, 32'hDEAD_BEEF, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 3'b010, 32'h0000_0020, 32'h2222_2222, 32'h1111_1111, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h0,         32'h2222_2222, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 3'b010, 32'h0000_0020, 32'h5555_5555, 32'h2222_2222, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 3'b010, 32'h0000_03FC, 32'h5A5A_5A5A, 32'h2222_2222, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 3'b010, 32'h0000_0000, 32'h0123_4567, 32'h2222_2222, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 3'b010, 32'h0000_03FC, 32'h0,         32'h5A5A_5A5A, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 3'b010, 32'h0000_0000, 32'h0,         32'h0123_4567, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 3'b010, 32'h0000_0013, 32'h4444_4444, 32'h0123_4567, 1'b1, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 3'b010, 32'h0000_0400, 32'h7777_7777, 32'hDEAD_BEEF, 1'b1, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 3'b010, 32'h0000_0000, 32'h0,         32'h0123_4567, 1'b1, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0,         32'h0000_0000, 1'b1, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 3'b010, 32'h0000_03FC, 32'h0,         32'h5A5A_5A5A, 1'b1, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 3'b010, 32'h0000_03FE, 32'h0,         32'h0000_0000, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 3'b010, 32'h8000_0010, 32'h9999_9999, 32'h0000_0000, 1'b1, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b1, 1'b1));

        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        ph_m  = 0;
        check("reset readData", dmem_bus.readData, 32'd0);
        check("reset accessDone", {31'd0, dmem_bus.accessDone}, 32'd0);
        check("reset addrError", {31'd0, dmem_bus.addrError}, 32'd0);
        last_rd  = 32'd0;
        last_err = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(i, tbl[i]);
        end

        // Store 0xCAFEF00D, reset at phase 7, then a load must complete on the 5th edge.
        run_vec(100, mk(1'b0, 1'b1, 3'b010, 32'h0, 32'hCAFE_F00D, last_rd, 1'b1, 1'b1));
        drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        while (ph_m != 7) step();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        ph_m  = 0;
        check("midreset readData", dmem_bus.readData, 32'd0);
        check("midreset accessDone", {31'd0, dmem_bus.accessDone}, 32'd0);
        check("midreset addrError", {31'd0, dmem_bus.addrError}, 32'd0);
        drive(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
        for (int e = 1; e <= 5; e++) begin
            step();
            if (e < 5) begin
                check($sformatf("postreset edge%0d readData", e), dmem_bus.readData, 32'd0);
                check($sformatf("postreset edge%0d accessDone", e), {31'd0, dmem_bus.accessDone}, 32'd0);
            end else begin
                check("postreset edge5 readData", dmem_bus.readData, 32'hCAFE_F00D);
                check("postreset edge5 accessDone", {31'd0, dmem_bus.accessDone}, 32'd1);
                check("postreset edge5 addrError", {31'd0, dmem_bus.addrError}, 32'd0);
            end
        end
        last_rd  = 32'hCAFE_F00D;
        last_err = 1'b0;

`ifdef DMEM_SUBWORD_EN
        run_vec(200, mk(1'b0, 1'b1, 3'b010, 32'h0, 32'h80FF_7F01, 32'hCAFE_F00D, 1'b1, 1'b0));
        run_vec(201, mk(1'b1, 1'b0, 3'b000, 32'h3, 32'h0,         32'hFFFF_FF80, 1'b1, 1'b0));
        run_vec(202, mk(1'b1, 1'b0, 3'b100, 32'h1, 32'h0,         32'h0000_007F, 1'b1, 1'b0));
        run_vec(203, mk(1'b0, 1'b1, 3'b001, 32'h2, 32'h0000_ABCD, 32'h0000_007F, 1'b1, 1'b0));
        run_vec(204, mk(1'b1, 1'b0, 3'b010, 32'h0, 32'h0,         32'hABCD_7F01, 1'b1, 1'b0));
        run_vec(205, mk(1'b1, 1'b0, 3'b001, 32'h1, 32'h0,         32'h0000_0000, 1'b1, 1'b1));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
